// File: rtl/fp32_addsub_pipe.sv
// fp32_addsub_pipe
//   Pipelined IEEE-754 single-precision add/subtract for the Vector ALU.
//   One operand pair per cycle in, one result per cycle out, results
//   leave in acceptance order with their tags.  Denormal operands and
//   underflowing results are flushed to signed zero.
//
//   Pipeline (one valid bit per register level):
//     capture   : operands, op already folded into the sign of B
//     stage 1   : unpack, classify specials, swap, align      -> s1_*
//     stage 2   : 27-bit extended mantissa add/subtract        -> s2_*
//     stage 3   : normalize, round-to-nearest-even, pack       -> out_*
//   An operand accepted on edge N is presented after edge N+3.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   in_valid / in_ready        operand handshake
//   A, B, op, in_tag           operands (op=1 -> A-B), opaque tag
//   out_valid / out_ready      result handshake
//   out, NaN_flag,
//   overflow_flag, out_tag     result, flags, tag of presented result
//
// Handshake: a transfer happens on a rising edge where valid and ready
// are both high.  Every pipeline register loads only when
// adv = !out_valid || out_ready, and in_ready = adv, so a stalled output
// freezes the whole pipe (bubbles included) and nothing is lost.
module fp32_addsub_pipe #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      A,
  input  logic [31:0]      B,
  input  logic             op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out,
  output logic             NaN_flag,
  output logic             overflow_flag,
  output logic [TAG_W-1:0] out_tag
);

  logic adv;

  // capture registers
  logic             v0_q;
  logic [31:0]      a0_q, b0_q;
  logic [TAG_W-1:0] tag0_q;

  // stage 1: unpack / align
  logic        a_zero, b_zero, a_nan, b_nan, a_inf, b_inf, swap;
  logic [30:0] mag_a, mag_b;
  logic [23:0] ma, mb, mx, my;
  logic [7:0]  ex, ey, diff;
  logic [53:0] y_wide;
  logic [26:0] y_al_d;
  logic        s1_nan_d, s1_inf_d, s1_infs_d, s1_nz_d;

  logic             v1_q, s1_sign_q, s1_sub_q, s1_nan_q, s1_inf_q, s1_infs_q, s1_nz_q;
  logic [7:0]       s1_exp_q;
  logic [26:0]      s1_mx_q, s1_my_q;
  logic [TAG_W-1:0] s1_tag_q;

  // stage 2: add
  logic [27:0]      s2_sum_d;
  logic             v2_q, s2_sign_q, s2_nan_q, s2_inf_q, s2_infs_q, s2_nz_q;
  logic [7:0]       s2_exp_q;
  logic [27:0]      s2_sum_q;
  logic [TAG_W-1:0] s2_tag_q;

  // stage 3: normalize / round / pack
  logic [4:0]        lz;
  logic [26:0]       m27;
  logic signed [9:0] e_norm, e_rnd;
  logic              rup, fcarry;
  logic [22:0]       frac;
  logic [31:0]       out_d;
  logic              nan_d, ovf_d;

  logic             out_v_q, nan_q, ovf_q;
  logic [31:0]      out_q;
  logic [TAG_W-1:0] out_tag_q;

  assign adv      = !out_v_q || out_ready;
  assign in_ready = adv;

  // ---------------- stage 1 ----------------
  assign a_zero = (a0_q[30:23] == 8'd0);
  assign b_zero = (b0_q[30:23] == 8'd0);
  assign a_nan  = (a0_q[30:23] == 8'hFF) && (a0_q[22:0] != 23'd0);
  assign b_nan  = (b0_q[30:23] == 8'hFF) && (b0_q[22:0] != 23'd0);
  assign a_inf  = (a0_q[30:23] == 8'hFF) && (a0_q[22:0] == 23'd0);
  assign b_inf  = (b0_q[30:23] == 8'hFF) && (b0_q[22:0] == 23'd0);

  // magnitudes with denormals already flushed to zero
  assign mag_a = a_zero ? 31'd0 : a0_q[30:0];
  assign mag_b = b_zero ? 31'd0 : b0_q[30:0];
  assign ma    = a_zero ? 24'd0 : {1'b1, a0_q[22:0]};
  assign mb    = b_zero ? 24'd0 : {1'b1, b0_q[22:0]};
  assign swap  = (mag_b > mag_a);
  assign ex    = swap ? mag_b[30:23] : mag_a[30:23];
  assign ey    = swap ? mag_a[30:23] : mag_b[30:23];
  assign mx    = swap ? mb : ma;
  assign my    = swap ? ma : mb;
  assign diff  = ex - ey;

  // Upper 27 bits are the aligned value, lower 27 bits are what fell off
  // and collapse into sticky.
  assign y_wide = {my, 3'b000, 27'd0} >> diff;
  assign y_al_d = (diff >= 8'd27) ? {26'd0, |my}
                                  : {y_wide[53:28], y_wide[27] | (|y_wide[26:0])};

  assign s1_nan_d  = a_nan || b_nan || (a_inf && b_inf && (a0_q[31] != b0_q[31]));
  assign s1_inf_d  = a_inf || b_inf;
  assign s1_infs_d = a_inf ? a0_q[31] : b0_q[31];
  assign s1_nz_d   = a_zero && b_zero && a0_q[31] && b0_q[31];

  // ---------------- stage 2 ----------------
  // X >= Y in magnitude, so the difference never goes negative.
  assign s2_sum_d = s1_sub_q ? ({1'b0, s1_mx_q} - {1'b0, s1_my_q})
                             : ({1'b0, s1_mx_q} + {1'b0, s1_my_q});

  // ---------------- stage 3 ----------------
  always_comb begin
    lz = 5'd0;
    for (int i = 0; i < 27; i++) begin
      if (s2_sum_q[i]) lz = 5'(26 - i);
    end
    if (s2_sum_q[27]) begin
      m27    = {s2_sum_q[27:2], s2_sum_q[1] | s2_sum_q[0]};
      e_norm = $signed({2'b00, s2_exp_q}) + 10'sd1;
    end else begin
      m27    = s2_sum_q[26:0] << lz;
      e_norm = $signed({2'b00, s2_exp_q}) - $signed({5'd0, lz});
    end
    // m27: [26] hidden, [25:3] fraction, [2] guard, [1:0] round/sticky
    rup            = m27[2] && ((|m27[1:0]) || m27[3]);
    {fcarry, frac} = {1'b0, m27[25:3]} + {23'd0, rup};
    // fraction overflow means 10.0 -> 1.0 with exponent +1, fraction 0
    e_rnd          = e_norm + $signed({9'd0, fcarry});

    out_d = {s2_sign_q, e_rnd[7:0], frac};
    nan_d = 1'b0;
    ovf_d = 1'b0;
    if (s2_nan_q) begin
      out_d = 32'h7FC0_0000;
      nan_d = 1'b1;
    end else if (s2_inf_q) begin
      out_d = {s2_infs_q, 8'hFF, 23'd0};
    end else if (!m27[26]) begin
      // exact zero; only (-0)+(-0) keeps the negative sign
      out_d = {s2_nz_q, 31'd0};
    end else if (e_rnd >= 10'sd255) begin
      out_d = {s2_sign_q, 8'hFF, 23'd0};
      ovf_d = 1'b1;
    end else if (e_rnd <= 10'sd0) begin
      out_d = {s2_sign_q, 31'd0};
    end
  end

  // ---------------- registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0_q      <= 1'b0;
      a0_q      <= '0;
      b0_q      <= '0;
      tag0_q    <= '0;
      v1_q      <= 1'b0;
      s1_sign_q <= 1'b0;
      s1_sub_q  <= 1'b0;
      s1_nan_q  <= 1'b0;
      s1_inf_q  <= 1'b0;
      s1_infs_q <= 1'b0;
      s1_nz_q   <= 1'b0;
      s1_exp_q  <= '0;
      s1_mx_q   <= '0;
      s1_my_q   <= '0;
      s1_tag_q  <= '0;
      v2_q      <= 1'b0;
      s2_sign_q <= 1'b0;
      s2_nan_q  <= 1'b0;
      s2_inf_q  <= 1'b0;
      s2_infs_q <= 1'b0;
      s2_nz_q   <= 1'b0;
      s2_exp_q  <= '0;
      s2_sum_q  <= '0;
      s2_tag_q  <= '0;
      out_v_q   <= 1'b0;
      out_q     <= '0;
      nan_q     <= 1'b0;
      ovf_q     <= 1'b0;
      out_tag_q <= '0;
    end else if (adv) begin
      v0_q      <= in_valid;
      a0_q      <= A;
      b0_q      <= {B[31] ^ op, B[30:0]};
      tag0_q    <= in_tag;

      v1_q      <= v0_q;
      s1_sign_q <= swap ? b0_q[31] : a0_q[31];
      s1_sub_q  <= a0_q[31] ^ b0_q[31];
      s1_nan_q  <= s1_nan_d;
      s1_inf_q  <= s1_inf_d;
      s1_infs_q <= s1_infs_d;
      s1_nz_q   <= s1_nz_d;
      s1_exp_q  <= ex;
      s1_mx_q   <= {mx, 3'b000};
      s1_my_q   <= y_al_d;
      s1_tag_q  <= tag0_q;

      v2_q      <= v1_q;
      s2_sign_q <= s1_sign_q;
      s2_nan_q  <= s1_nan_q;
      s2_inf_q  <= s1_inf_q;
      s2_infs_q <= s1_infs_q;
      s2_nz_q   <= s1_nz_q;
      s2_exp_q  <= s1_exp_q;
      s2_sum_q  <= s2_sum_d;
      s2_tag_q  <= s1_tag_q;

      out_v_q   <= v2_q;
      out_q     <= out_d;
      nan_q     <= nan_d;
      ovf_q     <= ovf_d;
      out_tag_q <= s2_tag_q;
    end
  end

  assign out_valid     = out_v_q;
  assign out           = out_q;
  assign NaN_flag      = nan_q;
  assign overflow_flag = ovf_q;
  assign out_tag       = out_tag_q;

endmodule

// File: tb/tb_fp32_addsub_pipe.sv
// Testbench for fp32_addsub_pipe: directed vectors, exact-arithmetic
// reference model, scoreboard queue checked on every output transfer.
module tb_fp32_addsub_pipe;
  localparam int TAG_W = 4;
  localparam int EW    = 34 + TAG_W;  // {result, nan, ovf, tag}
  localparam int NV    = 19;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      A, B;
  logic             op;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out;
  logic             NaN_flag, overflow_flag;
  logic [TAG_W-1:0] out_tag;

  fp32_addsub_pipe #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .op(op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .NaN_flag(NaN_flag), .overflow_flag(overflow_flag),
    .out_tag(out_tag)
  );

  int checks   = 0;
  int failures = 0;
  logic [EW-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  // Exact sum on a wide integer grid (unit = 2^-149), then round to 24
  // significant bits ties-to-even; returns {result, nan, ovf}.
  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b_in,
                                        input logic o);
    logic [31:0]  b;
    logic         a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sa, sb, s;
    logic [299:0] ia, ib, mag, keep, rem, half, one;
    int           p, sh, be;
    b      = {b_in[31] ^ o, b_in[30:0]};
    sa     = a[31];
    sb     = b[31];
    a_zero = (a[30:23] == 8'd0);
    b_zero = (b[30:23] == 8'd0);
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) return {32'h7FC00000, 1'b1, 1'b0};
    if (a_inf) return {sa, 8'hFF, 23'd0, 2'b00};
    if (b_inf) return {sb, 8'hFF, 23'd0, 2'b00};
    one = 300'd1;
    ia  = a_zero ? 300'd0 : ({276'd0, 1'b1, a[22:0]} << (int'(a[30:23]) - 1));
    ib  = b_zero ? 300'd0 : ({276'd0, 1'b1, b[22:0]} << (int'(b[30:23]) - 1));
    if (sa == sb) begin
      mag = ia + ib; s = sa;
    end else if (ia >= ib) begin
      mag = ia - ib; s = sa;
    end else begin
      mag = ib - ia; s = sb;
    end
    if (mag == 300'd0) return {(a_zero && b_zero && sa && sb), 31'd0, 2'b00};
    p = 0;
    for (int i = 0; i < 300; i++) if (mag[i]) p = i;
    if (p > 23) begin
      sh   = p - 23;
      keep = mag >> sh;
      rem  = mag - (keep << sh);
      half = one << (sh - 1);
      if ((rem > half) || ((rem == half) && keep[0])) keep = keep + one;
    end else begin
      keep = mag << (23 - p);
    end
    be = p - 22;
    if (keep[24]) begin
      keep = keep >> 1;
      be++;
    end
    if (be >= 255) return {s, 8'hFF, 23'd0, 2'b01};
    if (be <= 0)   return {s, 31'd0, 2'b00};
    return {s, 8'(be), keep[22:0], 2'b00};
  endfunction

  // ---------------- scoreboard / compare process ----------------
  logic          held_v = 1'b0;
  logic [EW-1:0] held;
  logic [EW-1:0] e;

  always @(negedge clk) begin
    if (!rst_n) begin
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        check("stall_out_valid", out_valid, 1);
        check("stall_hold", {out, NaN_flag, overflow_flag, out_tag}, held);
      end
      if (out_valid && !out_ready) check("stall_in_ready", in_ready, 0);
      if (out_valid) check("flags_exclusive", NaN_flag & overflow_flag, 0);
      if (in_valid && in_ready) exp_q.push_back({model(A, B, op), in_tag});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out: got out=%h tag=%h expected no result", out, out_tag);
        end else begin
          e = exp_q.pop_front();
          check("out_value", out, e[EW-1 -: 32]);
          check("nan_flag", NaN_flag, e[TAG_W+1]);
          check("overflow_flag", overflow_flag, e[TAG_W]);
          check("out_tag", out_tag, e[TAG_W-1:0]);
        end
      end
      held_v = out_valid && !out_ready;
      held   = {out, NaN_flag, overflow_flag, out_tag};
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 right after acceptance.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic o,
                      input logic [TAG_W-1:0] t);
    int n;
    A = a; B = b; op = o; in_tag = t; in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 50) begin
        check("send_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Output must appear exactly at the fourth negedge after acceptance.
  task automatic check_latency();
    repeat (3) begin
      @(negedge clk);
      check("latency_early", out_valid, 0);
    end
    @(negedge clk);
    check("latency_on_time", out_valid, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0) && (n < 100)) begin
      @(negedge clk);
      n++;
    end
    check("drain", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vectors ----------------
  logic [31:0] va   [NV];
  logic [31:0] vb   [NV];
  logic        vop  [NV];
  logic [33:0] vexp [NV];
  logic [33:0] m;
  int          n;

  initial begin
    va   = '{32'h3F800000, 32'h40400000, 32'hFF800000, 32'h7F800000, 32'h7F7FFFFF,
             32'h3F800000, 32'h3F800001, 32'h3FFFFFFF, 32'h80000000, 32'h80000000,
             32'h7F800001, 32'h3F800000, 32'h4B800000, 32'h00800000, 32'hC0A00000,
             32'h3F800000, 32'h7F000000, 32'h3F800000, 32'h3F800000};
    vb   = '{32'h3F800000, 32'h3F800000, 32'h7F800000, 32'h000000FF, 32'h7F7FFFFF,
             32'h33800000, 32'h33800000, 32'h33800000, 32'h80000000, 32'h00000000,
             32'h3F800000, 32'h3F7FFFFF, 32'h3F800000, 32'h00800001, 32'h40400000,
             32'h00000001, 32'h7F000000, 32'h4C000000, 32'h4E000000};
    vop  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
             1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vexp = '{{32'h00000000, 2'b00}, {32'h40000000, 2'b00}, {32'h7FC00000, 2'b10},
             {32'h7F800000, 2'b00}, {32'h7F800000, 2'b01}, {32'h3F800000, 2'b00},
             {32'h3F800002, 2'b00}, {32'h40000000, 2'b00}, {32'h80000000, 2'b00},
             {32'h80000000, 2'b00}, {32'h7FC00000, 2'b10}, {32'h33800000, 2'b00},
             {32'h4B800000, 2'b00}, {32'h80000000, 2'b00}, {32'hC0000000, 2'b00},
             {32'h3F800000, 2'b00}, {32'h7F800000, 2'b01}, {32'hCC000000, 2'b00},
             {32'h4E000000, 2'b00}};

    // reset state
    rst_n = 1'b0; in_valid = 1'b0; A = '0; B = '0; op = 1'b0; in_tag = '0;
    out_ready = 1'b1;
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_in_ready", in_ready, 1);
    check("reset_out", out, 0);
    check("reset_out_tag", out_tag, 0);
    check("reset_flags", {NaN_flag, overflow_flag}, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // pin the model itself against hand-computed values
    m = model(32'h3F800000, 32'h40000000, 1'b0);
    check("model_1p2", m, {32'h40400000, 2'b00});
    for (int i = 0; i < NV; i++) begin
      m = model(va[i], vb[i], vop[i]);
      check($sformatf("model_vec%0d", i), m, vexp[i]);
    end

    // basic latency: 1.0 + 2.0, tag 5
    send(32'h3F800000, 32'h40000000, 1'b0, 4'd5);
    check_latency();
    drain();

    // all directed vectors back to back
    for (int i = 0; i < NV; i++) send(va[i], vb[i], vop[i], 4'(i));
    drain();

    // backpressure: 6 ops, stall 5 cycles after first result
    fork
      begin
        for (int i = 0; i < 6; i++) send(va[i + 2], vb[i + 2], vop[i + 2], 4'(i));
      end
      begin
        n = 0;
        @(negedge clk);
        while (!out_valid && (n < 50)) begin
          @(negedge clk);
          n++;
        end
        check("bp_first_result", out_valid, 1);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // reset mid-flight
    out_ready = 1'b0;
    send(32'h3F800000, 32'h40000000, 1'b0, 4'd1);
    send(32'h40400000, 32'h3F800000, 1'b1, 4'd2);
    n = 0;
    @(negedge clk);
    while (!out_valid && (n < 20)) begin
      @(negedge clk);
      n++;
    end
    check("rst_pre_valid", out_valid, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_out_valid_drop", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_cleared", {out, out_tag, NaN_flag, overflow_flag}, 0);
    exp_q.delete();
    #5;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("post_rst_idle", out_valid, 0);
      check("post_rst_in_ready", in_ready, 1);
    end
    @(posedge clk);
    #1;
    send(32'h3F800000, 32'h3F800000, 1'b0, 4'd9);
    check_latency();
    drain();

    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
